// File: rtl/status_mon_pkg.sv
// Shared constants and types for the board status input monitor.
package status_mon_pkg;

  localparam int RD_DATA_W = 16;

  localparam logic [3:0] SEL_STABLE   = 4'd0;
  localparam logic [3:0] SEL_STICKY   = 4'd1;
  localparam logic [3:0] SEL_CNT_BASE = 4'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    ACK  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/status_debounce_ch.sv
// One monitored line: 2-FF synchroniser, hold-time debounce and edge pulses.
// Edge pulses are registered so they line up with the stable level update.
module status_debounce_ch #(
  parameter int   DEBOUNCE_CYC = 400000,
  parameter logic INIT_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  // Count consecutive cycles the synchronised level differs from the accepted one.
  always_comb begin
    deb_cnt_d = '0;
    stable_d  = stable_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (en && (sync2_q != stable_q)) begin
      if (deb_cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  // Synchroniser keeps running while disabled; debounce state only moves when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= INIT_VAL;
      sync2_q   <= INIT_VAL;
      stable_q  <= INIT_VAL;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= pin;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/status_input_monitor.sv
// Board status input monitor: debounced levels, edge pulses, sticky flags and
// saturating per-channel event counters, read through a single-outstanding port.
module status_input_monitor
  import status_mon_pkg::*;
#(
  parameter int              N_IN         = 6,
  parameter int              DEBOUNCE_CYC = 400000,
  parameter int              CNT_W        = 8,
  parameter logic [N_IN-1:0] INIT_VAL     = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 status_en,
  input  logic [N_IN-1:0]      pin_in,
  output logic [N_IN-1:0]      stable_out,
  output logic [N_IN-1:0]      rise_pulse,
  output logic [N_IN-1:0]      fall_pulse,
  input  logic                 rd_req,
  input  logic [3:0]           rd_sel,
  input  logic                 rd_clr,
  output logic                 rd_ack,
  output logic [RD_DATA_W-1:0] rd_data
);

  localparam logic [3:0]       SEL_LAST = 4'(N_IN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [N_IN-1:0]      stable_w, rise_w, fall_w, edge_w;
  logic [N_IN-1:0]      sticky_q, sticky_d;
  logic [CNT_W-1:0]     cnt_q [N_IN];
  logic [CNT_W-1:0]     cnt_d [N_IN];
  rd_state_e            state_q;
  logic [3:0]           sel_q;
  logic                 clr_q;
  logic                 rd_ack_q;
  logic [RD_DATA_W-1:0] rd_data_q;
  logic [RD_DATA_W-1:0] sel_value;
  logic [3:0]           ch_idx;
  logic                 sel_is_cnt;
  logic                 clr_sticky, clr_cnt;

  for (genvar g = 0; g < N_IN; g++) begin : g_ch
    status_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .INIT_VAL     (INIT_VAL[g])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (status_en),
      .pin     (pin_in[g]),
      .stable  (stable_w[g]),
      .rise    (rise_w[g]),
      .fall    (fall_w[g])
    );
  end

  assign edge_w     = rise_w | fall_w;
  assign ch_idx     = sel_q - SEL_CNT_BASE;
  assign sel_is_cnt = (sel_q >= SEL_CNT_BASE) && (sel_q <= SEL_LAST);
  // Clears land in the ACK cycle; logging is frozen while disabled, clears included.
  assign clr_sticky = status_en && (state_q == ACK) && clr_q && (sel_q == SEL_STICKY);
  assign clr_cnt    = status_en && (state_q == ACK) && clr_q && sel_is_cnt;

  // Event logging; an edge in the clear cycle survives the clear.
  always_comb begin
    sticky_d = clr_sticky ? edge_w : (sticky_q | edge_w);
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt && (ch_idx == 4'(i))) begin
        cnt_d[i] = edge_w[i] ? CNT_W'(1) : '0;
      end else if (edge_w[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Read mux; out-of-range selects read as zero.
  always_comb begin
    sel_value = '0;
    if (sel_q == SEL_STABLE) begin
      sel_value = RD_DATA_W'(stable_w);
    end else if (sel_q == SEL_STICKY) begin
      sel_value = RD_DATA_W'(sticky_q);
    end else if (sel_is_cnt) begin
      for (int i = 0; i < N_IN; i++) begin
        if (ch_idx == 4'(i)) sel_value = RD_DATA_W'(cnt_q[i]);
      end
    end
  end

  // Sticky and counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      sticky_q <= sticky_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Read FSM: latch request, capture pre-clear value with ack, then return to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      clr_q     <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req) begin
            sel_q   <= rd_sel;
            clr_q   <= rd_clr;
            state_q <= CAPT;
          end
        end
        CAPT: begin
          rd_data_q <= sel_value;
          rd_ack_q  <= 1'b1;
          state_q   <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stable_out = stable_w;
  assign rise_pulse = rise_w;
  assign fall_pulse = fall_w;
  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_status_input_monitor.sv
// Scoreboard bench for status_input_monitor with short debounce and narrow counters.
module tb_status_input_monitor;

  localparam int N_IN  = 6;
  localparam int DEB   = 4;
  localparam int CNT_W = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        status_en = 1'b1;
  logic [5:0]  pin_in = '0;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_sel = '0;
  logic        rd_clr = 1'b0;
  logic [5:0]  stable_out, rise_pulse, fall_pulse;
  logic        rd_ack;
  logic [15:0] rd_data;

  status_input_monitor #(
    .N_IN         (N_IN),
    .DEBOUNCE_CYC (DEB),
    .CNT_W        (CNT_W),
    .INIT_VAL     (6'b000000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .status_en  (status_en),
    .pin_in     (pin_in),
    .stable_out (stable_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_clr     (rd_clr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [5:0] rise; logic [5:0] fall; logic [5:0] stable; } ev_exp_t;
  rd_exp_t rd_q[$];
  ev_exp_t ev_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack and every edge pulse must match the head of its queue.
  always @(negedge clk) begin
    rd_exp_t re;
    ev_exp_t ee;
    if (rd_ack) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: rd_data=%0h at cycle %0d with no read outstanding", rd_data, cyc);
      end else begin
        re = rd_q.pop_front();
        chk("ack_cycle", cyc, re.cyc);
        chk("rd_data", rd_data, re.data);
      end
    end
    if ((rise_pulse | fall_pulse) != '0) begin
      if (ev_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d", rise_pulse, fall_pulse, cyc);
      end else begin
        ee = ev_q.pop_front();
        chk("pulse_cycle", cyc, ee.cyc);
        chk("rise_pulse", rise_pulse, ee.rise);
        chk("fall_pulse", fall_pulse, ee.fall);
        chk("stable_at_pulse", stable_out, ee.stable);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_ev(input int c, input logic [5:0] r, input logic [5:0] f, input logic [5:0] s);
    ev_exp_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.stable = s;
    ev_q.push_back(e);
  endtask

  task automatic do_read(input logic [3:0] sel, input logic clr, input logic [15:0] exp);
    rd_exp_t e;
    e.cyc  = cyc + 2;
    e.data = exp;
    rd_q.push_back(e);
    rd_req = 1'b1;
    rd_sel = sel;
    rd_clr = clr;
    tick(1);
    rd_req = 1'b0;
    rd_clr = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    pin_in  = '0;
    rd_req  = 1'b0;
    reset_n = 1'b0;
    tick(2);
    chk("rst_stable", stable_out, 6'b0);
    chk("rst_rise", rise_pulse, 6'b0);
    chk("rst_fall", fall_pulse, 6'b0);
    chk("rst_ack", rd_ack, 1'b0);
    chk("rst_data", rd_data, 16'h0);
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int c;
    tick(1);
    do_reset();

    // 1: single rise on ch0, 6 cycles pin-to-pulse
    c = cyc; pin_in[0] = 1'b1;
    exp_ev(c + 6, 6'b000001, 6'b0, 6'b000001);
    tick(10);
    do_read(4'd0, 1'b0, 16'h0001);
    do_read(4'd2, 1'b0, 16'h0001);
    do_read(4'd1, 1'b0, 16'h0001);

    // 2: 3-cycle glitch on ch1 is rejected
    pin_in[1] = 1'b1;
    tick(3);
    pin_in[1] = 1'b0;
    tick(10);
    do_read(4'd1, 1'b0, 16'h0001);
    do_read(4'd3, 1'b0, 16'h0000);
    do_read(4'd0, 1'b0, 16'h0001);

    // 3: nine accepted edges on ch2 saturate its counter at 7
    do_reset();
    for (int j = 0; j < 9; j++) begin
      c = cyc;
      pin_in[2] = (j % 2 == 0);
      if (j % 2 == 0) exp_ev(c + 6, 6'b000100, 6'b0, 6'b000100);
      else            exp_ev(c + 6, 6'b0, 6'b000100, 6'b0);
      tick(10);
    end
    do_read(4'd4, 1'b0, 16'd7);
    do_read(4'd1, 1'b0, 16'h0004);

    // 4: clear-on-read returns pre-clear value; edge in clear cycle wins
    do_read(4'd1, 1'b1, 16'h0004);
    do_read(4'd1, 1'b0, 16'h0000);
    do_read(4'd4, 1'b1, 16'd7);
    do_read(4'd4, 1'b0, 16'd0);
    c = cyc; pin_in[3] = 1'b1;
    exp_ev(c + 6, 6'b001000, 6'b0, 6'b001100);
    tick(4);
    do_read(4'd1, 1'b1, 16'h0000);
    do_read(4'd1, 1'b0, 16'h0008);
    do_read(4'd5, 1'b0, 16'd1);
    c = cyc; pin_in[3] = 1'b0;
    exp_ev(c + 6, 6'b0, 6'b001000, 6'b000100);
    tick(4);
    do_read(4'd5, 1'b1, 16'd1);
    do_read(4'd5, 1'b0, 16'd1);

    // 5: disabled monitoring freezes logging; re-enable needs full debounce
    status_en = 1'b0;
    pin_in[4] = 1'b1;
    tick(20);
    do_read(4'd0, 1'b0, 16'h0004);
    do_read(4'd6, 1'b0, 16'd0);
    do_read(4'd1, 1'b0, 16'h0008);
    c = cyc; status_en = 1'b1;
    exp_ev(c + 4, 6'b010000, 6'b0, 6'b010100);
    tick(8);
    do_read(4'd6, 1'b0, 16'd1);
    do_read(4'd9, 1'b0, 16'd0);
    do_read(4'd1, 1'b0, 16'h0018);

    // 6: requests while busy are dropped; reset mid-read loses the ack
    c = cyc; pin_in[5] = 1'b1;
    exp_ev(c + 6, 6'b100000, 6'b0, 6'b110100);
    tick(10);
    begin
      rd_exp_t e;
      e.cyc = cyc + 2; e.data = 16'd1;
      rd_q.push_back(e);
    end
    rd_req = 1'b1; rd_sel = 4'd7;
    tick(1);
    rd_sel = 4'd0;
    tick(1);
    tick(1);
    rd_req = 1'b0;
    tick(3);
    rd_req = 1'b1; rd_sel = 4'd7;
    tick(1);
    rd_req = 1'b0;
    do_reset();
    tick(3);
    do_read(4'd7, 1'b0, 16'd0);
    do_read(4'd0, 1'b0, 16'd0);

    tick(5);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("ev_queue_drained", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
